// File: rtl/ibex_pkg.sv
// -----------------------------------------------------------------------------
// ibex_pkg (dummy-instruction slice)
//
// Shared definitions for the dummy-instruction generator and tracker:
//   - dummy_instr_e    : the four operations the generator may insert
//   - OPCODE_OP        : major opcode of every dummy (R-type OP)
//   - F7_* / F3_*      : funct7/funct3 pairs for each dummy operation
//   - dummy_funct()    : maps a dummy operation to its {funct7, funct3}
//   - dummy_track_t    : per-slot tracking record {valid, dummy, enc_ok}
//   - GAP_W / CNT_W    : widths of the insertion-gap and retired-dummy counters
// -----------------------------------------------------------------------------
package ibex_pkg;

   typedef enum logic [1:0] {
      DUMMY_ADD = 2'b00,
      DUMMY_MUL = 2'b01,
      DUMMY_DIV = 2'b10,
      DUMMY_AND = 2'b11
   } dummy_instr_e;

   localparam logic [6:0] OPCODE_OP = 7'h33;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [6:0] F7_MUL = 7'b0000001;
   localparam logic [2:0] F3_MUL = 3'b000;
   localparam logic [6:0] F7_DIV = 7'b0000001;
   localparam logic [2:0] F3_DIV = 3'b100;
   localparam logic [6:0] F7_AND = 7'b0000000;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam int unsigned GAP_W = 6;
   localparam int unsigned CNT_W = 16;

   typedef struct packed {
      logic valid;
      logic dummy;
      logic enc_ok;
   } dummy_track_t;

   // {funct7, funct3} that the generator emits for a given dummy operation.
   function automatic logic [9:0] dummy_funct(input dummy_instr_e op);
      logic [9:0] funct;
      case (op)
         DUMMY_ADD: funct = {F7_ADD, F3_ADD};
         DUMMY_MUL: funct = {F7_MUL, F3_MUL};
         DUMMY_DIV: funct = {F7_DIV, F3_DIV};
         DUMMY_AND: funct = {F7_AND, F3_AND};
         default:   funct = {F7_ADD, F3_ADD};
      endcase
      return funct;
   endfunction

endpackage

// File: rtl/ibex_dummy_instr_check.sv
// -----------------------------------------------------------------------------
// ibex_dummy_instr_check
//
// Purely combinational check that an instruction word is an encoding the
// dummy generator can produce: OP opcode, rd = x0, and one of the four
// allowed {funct7, funct3} pairs. rs1/rs2 are free and not inspected.
//
// Ports:
//   instr_rdata  in  32  instruction word to check
//   enc_ok       out  1  word is a legal dummy encoding
// -----------------------------------------------------------------------------
module ibex_dummy_instr_check
   import ibex_pkg::*;
(
   input  logic [31:0] instr_rdata,
   output logic        enc_ok
);

   logic [9:0] funct;
   logic       funct_ok;
   logic       unused_rs;

   assign funct = {instr_rdata[31:25], instr_rdata[14:12]};

   // Source registers carry the generator's random operands.
   assign unused_rs = ^instr_rdata[24:15];

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block leaves it unassigned and a latch is never inferred.
   always_comb begin
      funct_ok = 1'b0;
      if (funct == dummy_funct(DUMMY_ADD) || funct == dummy_funct(DUMMY_MUL) ||
          funct == dummy_funct(DUMMY_DIV) || funct == dummy_funct(DUMMY_AND)) begin
         funct_ok = 1'b1;
      end
   end

   assign enc_ok = (instr_rdata[6:0] == OPCODE_OP) &&
                   (instr_rdata[11:7] == 5'd0) &&
                   funct_ok;

endmodule

// File: rtl/ibex_dummy_instr_tracker.sv
// -----------------------------------------------------------------------------
// ibex_dummy_instr_tracker
//
// Follows dummy-tagged instructions from the ID handshake to retirement.
// Flags a dummy held in ID/EX so its register write is suppressed, pulses a
// retire indication (dummy or real) so performance counters can skip dummies,
// counts retired dummies, and latches an integrity error on a malformed dummy
// or an over-long run of real retires between dummies.
//
// Parameters:
//   WritebackStage  1 = retire from a separate WB slot, 0 = retire at ID/EX
//   MaxGap          most real retires allowed between two dummies
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   dummy_instr_en_i       dummy insertion enabled
//   instr_valid_id_i       instruction presented to ID
//   id_in_ready_i          ID accepts the presented instruction
//   instr_is_dummy_i       presented instruction is a dummy
//   instr_rdata_i [31:0]   presented instruction word
//   id_done_i              instruction in ID/EX completes
//   wb_done_i              instruction in WB retires (WritebackStage=1 only)
//   flush_i                kill the instruction in ID/EX
//   cnt_clr_i              clear the retired-dummy count
//   dummy_in_id_o          ID/EX holds a dummy (registered)
//   dummy_retire_o         a dummy retires this cycle
//   real_retire_o          a non-dummy retires this cycle
//   dummy_cnt_o [15:0]     retired dummies, saturating
//   err_o                  sticky integrity error
// -----------------------------------------------------------------------------
module ibex_dummy_instr_tracker
   import ibex_pkg::*;
#(
   parameter bit          WritebackStage = 1'b0,
   parameter int unsigned MaxGap         = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             dummy_instr_en_i,
   input  logic             instr_valid_id_i,
   input  logic             id_in_ready_i,
   input  logic             instr_is_dummy_i,
   input  logic [31:0]      instr_rdata_i,
   input  logic             id_done_i,
   input  logic             wb_done_i,
   input  logic             flush_i,
   input  logic             cnt_clr_i,
   output logic             dummy_in_id_o,
   output logic             dummy_retire_o,
   output logic             real_retire_o,
   output logic [CNT_W-1:0] dummy_cnt_o,
   output logic             err_o
);

   localparam logic [GAP_W:0] MAX_GAP = (GAP_W + 1)'(MaxGap);

   logic             accept;
   logic             enc_ok;
   logic             id_fin;
   logic             retire;
   logic             retire_dummy;
   logic             retire_enc_ok;
   logic             enc_err;
   logic             gap_over;
   logic [GAP_W:0]   gap_inc;

   dummy_track_t     id_q, id_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   ibex_dummy_instr_check u_check (
      .instr_rdata (instr_rdata_i),
      .enc_ok      (enc_ok)
   );

   assign accept = instr_valid_id_i & id_in_ready_i;
   // Completion only counts when the slot actually holds an instruction.
   assign id_fin = id_done_i & id_q.valid;

   // --------------------------------------------------------------------------
   // ID/EX slot
   // --------------------------------------------------------------------------
   // Accept wins over completion/flush: the old instruction leaves and the new
   // one lands in the same edge. Flush alongside completion clears the slot
   // exactly as completion alone would.
   always_comb begin
      id_d = id_q;
      if (accept) begin
         id_d = '{valid: 1'b1, dummy: instr_is_dummy_i, enc_ok: enc_ok};
      end else if (id_fin || flush_i) begin
         id_d = '0;
      end
   end

   // --------------------------------------------------------------------------
   // Retire point: either a separate WB slot or ID/EX completion itself
   // --------------------------------------------------------------------------
   if (WritebackStage) begin : g_wb
      dummy_track_t wb_q, wb_d;
      logic         wb_fin;

      assign wb_fin = wb_done_i & wb_q.valid;

      // A completing ID instruction overwrites the WB slot; if WB retires in
      // the same cycle the outgoing entry is still reported from wb_q.
      always_comb begin
         wb_d = wb_q;
         if (id_fin) begin
            wb_d = id_q;
         end else if (wb_fin) begin
            wb_d = '0;
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            wb_q <= '0;
         end else begin
            wb_q <= wb_d;
         end
      end

      assign retire        = wb_fin;
      assign retire_dummy  = wb_q.dummy;
      assign retire_enc_ok = wb_q.enc_ok;
   end else begin : g_no_wb
      logic unused_wb_done;

      assign unused_wb_done = wb_done_i;
      assign retire         = id_fin;
      assign retire_dummy   = id_q.dummy;
      assign retire_enc_ok  = id_q.enc_ok;
   end

   // --------------------------------------------------------------------------
   // Gap counter, retired-dummy counter, error latch
   // --------------------------------------------------------------------------
   assign gap_inc  = {1'b0, gap_q} + 1'b1;
   assign gap_over = retire & ~retire_dummy & dummy_instr_en_i & (gap_inc > MAX_GAP);
   // The error is flagged at acceptance, before the dummy ever reaches retire.
   assign enc_err  = accept & instr_is_dummy_i & ~enc_ok;

   always_comb begin
      gap_d = gap_q;
      if (!dummy_instr_en_i || (retire && retire_dummy)) begin
         gap_d = '0;
      end else if (retire) begin
         // Hold at all-ones instead of wrapping; the error is already latched.
         gap_d = gap_inc[GAP_W] ? gap_q : gap_inc[GAP_W-1:0];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (retire && retire_dummy && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign err_d = err_q | enc_err | gap_over;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement or process order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_q  <= '0;
         gap_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         id_q  <= id_d;
         gap_q <= gap_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign dummy_in_id_o  = id_q.valid & id_q.dummy;
   assign dummy_retire_o = retire & retire_dummy;
   assign real_retire_o  = retire & ~retire_dummy;
   assign dummy_cnt_o    = cnt_q;
   assign err_o          = err_q;

   // --------------------------------------------------------------------------
   // Properties
   // --------------------------------------------------------------------------
   a_retire_exclusive : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dummy_retire_o && real_retire_o));

   // A malformed dummy can only reach retirement after the error was latched.
   a_bad_dummy_flagged : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (retire && retire_dummy && !retire_enc_ok) |-> err_q);

endmodule
